// File: rtl/prog_mem_loader.sv
// Program memory with a byte-stream loader. Bytes are packed little-endian into
// words during a load; fetches read the memory on the falling edge and return NOP while busy.
module prog_mem_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  overflow
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic                  ovf_q, ovf_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  last_byte_c;
  logic                  pending_c;

  // Storage has no reset so a reset mid-load keeps already written words.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state, word assembly and memory write control.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    idx_d       = idx_q;
    wbuf_d      = wbuf_q;
    words_d     = words_q;
    ovf_d       = ovf_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_q;
    mem_wdata_c = wbuf_q;
    word_c      = wbuf_q;
    last_byte_c = (idx_q == IDX_W'(BYTES - 1));
    pending_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
          idx_d     = '0;
          wbuf_d    = '0;
          words_d   = '0;
          ovf_d     = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) word_c[8*k +: 8] = load_byte;
          end
        end
        if (load_valid && last_byte_c) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = word_c;
          words_d     = words_q + CNT_W'(1);
          idx_d       = '0;
          wbuf_d      = '0;
          if (&wr_addr_q) state_d = FULL;
          else            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end else if (load_valid) begin
          idx_d  = idx_q + IDX_W'(1);
          wbuf_d = word_c;
        end
        // A partial word left after this cycle's byte is flushed with zero upper bytes.
        pending_c = load_valid ? !last_byte_c : (idx_q != '0);
        if (load_end) begin
          state_d = IDLE;
          if (pending_c) begin
            mem_we_c    = 1'b1;
            mem_wdata_c = word_c;
            words_d     = words_q + CNT_W'(1);
            idx_d       = '0;
            wbuf_d      = '0;
          end
        end
      end
      FULL: begin
        if (load_valid) ovf_d = 1'b1;
        if (load_end)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    data_d  = busy_q ? '0 : mem_q[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      idx_q     <= '0;
      wbuf_q    <= '0;
      words_q   <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      idx_q     <= idx_d;
      wbuf_q    <= wbuf_d;
      words_q   <= words_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  // Fetch port runs on the falling edge, half a cycle after control updates.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data         = data_q;
  assign load_ready   = ready_q;
  assign busy         = busy_q;
  assign words_loaded = words_q;
  assign overflow     = ovf_q;

endmodule
